// File: rtl/stream_demux_1to3_pkg.sv
// rtl/stream_demux_1to3_pkg.sv - select encodings, channel count and select decode shared by the 1-to-3 stream demux
package stream_demux_1to3_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] SEL_CH0     = 2'b00;
  localparam logic [1:0] SEL_CH1     = 2'b01;
  localparam logic [1:0] SEL_CH2     = 2'b10;
  localparam logic [1:0] SEL_SPECIAL = 2'b11;

  // One-hot channel decode; SEL_SPECIAL shifts past the top channel and yields zero.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/demux_out_slice.sv
// rtl/demux_out_slice.sv - one-deep registered output slot for a single demux channel
module demux_out_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  free
);

  // A full slot being drained this cycle can accept a new beat on the same edge.
  assign free = !valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      valid <= 1'b1;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1to3.sv
// rtl/stream_demux_1to3.sv - 1-to-3 stream demux; STREAM_DEMUX_BCAST_EN makes sel=11 broadcast instead of an illegal-select drop
module stream_demux_1to3
  import stream_demux_1to3_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data [NUM_CH-1:0],
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic                  err_sel
);

  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] sel_hot;
`ifndef STREAM_DEMUX_BCAST_EN
  logic              illegal;
`endif

  always_comb begin
    sel_hot  = sel_onehot(in_sel);
    in_ready = |(sel_hot & free);
    load     = sel_hot & free & {NUM_CH{in_valid}};
`ifdef STREAM_DEMUX_BCAST_EN
    if (in_sel == SEL_SPECIAL) begin
      in_ready = &free;
      load     = {NUM_CH{in_valid & (&free)}};
    end
`else
    illegal = 1'b0;
    // Illegal selects are always accepted so a bad producer cannot wedge the input.
    if (in_sel == SEL_SPECIAL) begin
      in_ready = 1'b1;
      illegal  = in_valid;
    end
`endif
  end

`ifdef STREAM_DEMUX_BCAST_EN
  assign err_sel = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
    end else if (illegal) begin
      err_sel <= 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_out_slice #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .data_in   (in_data),
      .out_ready (out_ready[i]),
      .data      (out_data[i]),
      .valid     (out_valid[i]),
      .free      (free[i])
    );
  end

endmodule

// File: tb/tb_stream_demux_1to3.sv
// tb/tb_stream_demux_1to3.sv - directed and random checks of stream_demux_1to3 (sel=11 expectations follow STREAM_DEMUX_BCAST_EN)
module tb_stream_demux_1to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data [2:0];
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic       err_sel;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq [3][$];
  logic       merr;
  logic [2:0] free_m;
  logic       exp_rdy;
  logic [1:0] seq_sel [4];

  stream_demux_1to3 #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst_n = 0; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 3'b111;
    #2;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk("rst_in_ready", 32'(in_ready), 1);
    end
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err_sel", 32'(err_sel), 0);
    for (int i = 0; i < 3; i++) chk("rst_slot_data", 32'(out_data[i]), 0);
    tick();

    // basic routing, first beat offered right after reset release
    rst_n = 1; in_sel = 2'b01; in_data = 8'hA5; in_valid = 1; out_ready = 3'b111;
    #1 chk("basic_ready", 32'(in_ready), 1);
    tick(); in_valid = 0;
    chk("basic_valid", 32'(out_valid), 32'b010);
    chk("basic_data", 32'(out_data[1]), 32'hA5);
    tick();
    chk("basic_drain", 32'(out_valid), 0);

    // backpressure on channel 2
    out_ready = 3'b011; in_sel = 2'b10; in_data = 8'h11; in_valid = 1;
    #1 chk("bp_ready1", 32'(in_ready), 1);
    tick(); in_data = 8'h22;
    #1 chk("bp_stall", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 32'b100);
    chk("bp_hold", 32'(out_data[2]), 32'h11);
    tick();
    chk("bp_stall2", 32'(in_ready), 0);
    chk("bp_hold2", 32'(out_data[2]), 32'h11);
    out_ready = 3'b111;
    #1 chk("bp_ready2", 32'(in_ready), 1);
    tick(); in_valid = 0;
    chk("bp_valid2", 32'(out_valid), 32'b100);
    chk("bp_data2", 32'(out_data[2]), 32'h22);
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // full throughput
    seq_sel[0] = 2'b00; seq_sel[1] = 2'b01; seq_sel[2] = 2'b10; seq_sel[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      in_sel = seq_sel[k]; in_data = 8'(k + 1); in_valid = 1;
      #1 chk("tp_ready", 32'(in_ready), 1);
      tick();
      chk("tp_valid", 32'(out_valid), 32'(1) << seq_sel[k]);
      chk("tp_data", 32'(out_data[seq_sel[k]]), 32'(k + 1));
    end
    in_valid = 0;
    tick();
    chk("tp_drain", 32'(out_valid), 0);

    // sel=11 with slot 0 held full
    out_ready = 3'b110; in_sel = 2'b00; in_data = 8'h77; in_valid = 1;
    tick();
    in_sel = 2'b11; in_data = 8'h5A;
`ifdef STREAM_DEMUX_BCAST_EN
    #1 chk("bc_stall", 32'(in_ready), 0);
    tick();
    chk("bc_hold", 32'(out_valid), 32'b001);
    out_ready = 3'b111;
    #1 chk("bc_ready", 32'(in_ready), 1);
    tick(); in_valid = 0; out_ready = 3'b000;
    chk("bc_valid", 32'(out_valid), 32'b111);
    for (int i = 0; i < 3; i++) chk("bc_data", 32'(out_data[i]), 32'h5A);
    chk("bc_err", 32'(err_sel), 0);
`else
    #1 chk("ill_ready", 32'(in_ready), 1);
    tick(); in_valid = 0;
    chk("ill_valid", 32'(out_valid), 32'b001);
    chk("ill_data0", 32'(out_data[0]), 32'h77);
    chk("ill_err", 32'(err_sel), 1);
    tick();
    chk("ill_err_held", 32'(err_sel), 1);
    chk("ill_valid_held", 32'(out_valid), 32'b001);
`endif
    #2 rst_n = 0;
    #1 chk("arst_valid", 32'(out_valid), 0);
    chk("arst_err", 32'(err_sel), 0);
    rst_n = 1; out_ready = 3'b111;
    tick();

    // random traffic against per-channel queues
    merr = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        chk("rnd_valid", 32'(out_valid[i]), 32'(mq[i].size() != 0));
        if (mq[i].size() != 0) chk("rnd_data", 32'(out_data[i]), 32'(mq[i][0]));
      end
      chk("rnd_err", 32'(err_sel), 32'(merr));
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      in_data   = 8'($urandom);
      out_ready = 3'($urandom);
      for (int i = 0; i < 3; i++) free_m[i] = (mq[i].size() == 0) || out_ready[i];
`ifdef STREAM_DEMUX_BCAST_EN
      exp_rdy = (in_sel == 2'b11) ? (&free_m) : free_m[in_sel];
`else
      exp_rdy = (in_sel == 2'b11) ? 1'b1 : free_m[in_sel];
`endif
      #1 chk("rnd_ready", 32'(in_ready), 32'(exp_rdy));
      for (int i = 0; i < 3; i++)
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel != 2'b11) mq[in_sel].push_back(in_data);
`ifdef STREAM_DEMUX_BCAST_EN
        else for (int i = 0; i < 3; i++) mq[i].push_back(in_data);
`else
        else merr = 1;
`endif
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
